// File: rtl/commit_unit_if.sv
// Commit-stage types and the ROB-to-commit interface.
// The ROB side drives the commit stream; commit_unit drives the results.
package commit_pkg;

  typedef enum logic [1:0] {
    RF_GPR  = 2'd0,
    RF_FPR  = 2'd1,
    RF_NONE = 2'd2
  } RegType_t;

  typedef struct packed {
    RegType_t   regtype;
    logic [5:0] addr;
  } RegFile_t;

  typedef enum logic [3:0] {
    EXP_IMISALIGN = 4'h0,
    EXP_IFAULT    = 4'h1,
    EXP_ILLEGAL   = 4'h2,
    EXP_BREAK     = 4'h3,
    EXP_LMISALIGN = 4'h4,
    EXP_LFAULT    = 4'h5,
    EXP_SMISALIGN = 4'h6,
    EXP_SFAULT    = 4'h7,
    EXP_ECALL_U   = 4'h8,
    EXP_ECALL_M   = 4'hb
  } ExpCode_t;

endpackage

interface commit_if
  import commit_pkg::*;
#(
  parameter int DATA = 32,
  parameter int ADDR = 32,
  parameter int ROB  = 5,
  parameter int CNT  = 64
);
  logic            commit_e_;
  logic            commit_jump_;
  logic            flush_;
  logic [ADDR-1:0] commit_pc;
  RegFile_t        commit_rd;
  logic [DATA-1:0] commit_data;
  logic            commit_exp_;
  ExpCode_t        commit_exp_code;
  logic [ADDR-1:0] exp_handler_pc;
  logic [ROB-1:0]  commit_rob_id;

  logic            arf_we_;
  logic [4:0]      arf_waddr;
  logic [DATA-1:0] arf_wdata;
  logic            redirect_e_;
  logic [ADDR-1:0] redirect_pc;
  logic            fe_hold;
  logic            exp_e_;
  logic [ADDR-1:0] exp_epc;
  ExpCode_t        exp_cause;
  logic [CNT-1:0]  instret;
  logic [ROB-1:0]  last_rob_id;

  modport master (
    output commit_e_, commit_jump_, flush_,
    output commit_pc, commit_rd, commit_data,
    output commit_exp_, commit_exp_code,
    output exp_handler_pc, commit_rob_id,
    input  arf_we_, arf_waddr, arf_wdata,
    input  redirect_e_, redirect_pc, fe_hold,
    input  exp_e_, exp_epc, exp_cause,
    input  instret, last_rob_id
  );

  modport slave (
    input  commit_e_, commit_jump_, flush_,
    input  commit_pc, commit_rd, commit_data,
    input  commit_exp_, commit_exp_code,
    input  exp_handler_pc, commit_rob_id,
    output arf_we_, arf_waddr, arf_wdata,
    output redirect_e_, redirect_pc, fe_hold,
    output exp_e_, exp_epc, exp_cause,
    output instret, last_rob_id
  );

endinterface

// File: rtl/commit_unit.sv
// Retirement stage: ARF writeback, precise trap capture,
// fetch redirect with a fixed front-end drain window.
module commit_unit
  import commit_pkg::*;
#(
  parameter int DATA         = 32,
  parameter int ADDR         = 32,
  parameter int ROB_DEPTH    = 32,
  parameter int ROB          = $clog2(ROB_DEPTH),
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT          = 64
) (
  input logic     clk,
  input logic     reset,
  commit_if.slave cif
);

  typedef enum logic [1:0] {
    RUN,
    REDIRECT,
    DRAIN
  } state_t;

  localparam logic [3:0] DrainInit = 4'(FLUSH_CYCLES - 1);

  state_t          state_q;
  logic [3:0]      cnt_q;
  logic            arf_we_q;
  logic [4:0]      arf_waddr_q;
  logic [DATA-1:0] arf_wdata_q;
  logic            redirect_e_q;
  logic [ADDR-1:0] redirect_pc_q;
  logic            fe_hold_q;
  logic            exp_e_q;
  logic [ADDR-1:0] exp_epc_q;
  ExpCode_t        exp_cause_q;
  logic [CNT-1:0]  instret_q;
  logic [ROB-1:0]  last_rob_id_q;

  logic take, gpr_wr;
  logic unused_ok;

  assign take   = !cif.commit_e_ && (state_q == RUN);
  assign gpr_wr = (cif.commit_rd.regtype == RF_GPR)
               && (cif.commit_rd.addr != 6'd0);

  // Jumps retire like any other op; the link write is a plain rd write.
  assign unused_ok = ^{cif.commit_jump_, cif.commit_rd.addr[5]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= RUN;
      cnt_q         <= '0;
      arf_we_q      <= 1'b1;
      arf_waddr_q   <= '0;
      arf_wdata_q   <= '0;
      redirect_e_q  <= 1'b1;
      redirect_pc_q <= '0;
      fe_hold_q     <= 1'b0;
      exp_e_q       <= 1'b1;
      exp_epc_q     <= '0;
      exp_cause_q   <= EXP_IMISALIGN;
      instret_q     <= '0;
      last_rob_id_q <= '0;
    end else begin
      arf_we_q     <= 1'b1;
      redirect_e_q <= 1'b1;
      exp_e_q      <= 1'b1;
      unique case (state_q)
        RUN: begin
          if (take) begin
            if (!cif.commit_exp_) begin
              exp_e_q       <= 1'b0;
              exp_epc_q     <= cif.commit_pc;
              exp_cause_q   <= cif.commit_exp_code;
              redirect_e_q  <= 1'b0;
              redirect_pc_q <= cif.exp_handler_pc;
              fe_hold_q     <= 1'b1;
              state_q       <= REDIRECT;
            end else begin
              if (gpr_wr) begin
                arf_we_q    <= 1'b0;
                arf_waddr_q <= cif.commit_rd.addr[4:0];
                arf_wdata_q <= cif.commit_data;
              end
              instret_q     <= instret_q + CNT'(1);
              last_rob_id_q <= cif.commit_rob_id;
              if (!cif.flush_) begin
                redirect_e_q  <= 1'b0;
                redirect_pc_q <= cif.commit_data[ADDR-1:0];
                fe_hold_q     <= 1'b1;
                state_q       <= REDIRECT;
              end
            end
          end
        end
        REDIRECT: begin
          cnt_q   <= DrainInit;
          state_q <= DRAIN;
        end
        DRAIN: begin
          if (cnt_q == 4'd0) begin
            fe_hold_q <= 1'b0;
            state_q   <= RUN;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign cif.arf_we_     = arf_we_q;
  assign cif.arf_waddr   = arf_waddr_q;
  assign cif.arf_wdata   = arf_wdata_q;
  assign cif.redirect_e_ = redirect_e_q;
  assign cif.redirect_pc = redirect_pc_q;
  assign cif.fe_hold     = fe_hold_q;
  assign cif.exp_e_      = exp_e_q;
  assign cif.exp_epc     = exp_epc_q;
  assign cif.exp_cause   = exp_cause_q;
  assign cif.instret     = instret_q;
  assign cif.last_rob_id = last_rob_id_q;

endmodule

// File: tb/tb_commit_unit.sv
// Directed bench for commit_unit: a 64-bit instret build and
// an 8-bit instret build share one stimulus stream.
module tb_commit_unit;
  import commit_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic        c_e_ = 1'b1;
  logic        c_jump_ = 1'b1;
  logic        c_flush_ = 1'b1;
  logic [31:0] c_pc = '0;
  RegFile_t    c_rd = '{regtype: RF_GPR, addr: 6'd0};
  logic [31:0] c_data = '0;
  logic        c_exp_ = 1'b1;
  ExpCode_t    c_code = EXP_IMISALIGN;
  logic [31:0] c_hpc = '0;
  logic [4:0]  c_id = '0;

  commit_if #(.DATA(32), .ADDR(32), .ROB(5), .CNT(64)) cif ();
  commit_if #(.DATA(32), .ADDR(32), .ROB(5), .CNT(8))  c8 ();

  assign cif.commit_e_       = c_e_;
  assign cif.commit_jump_    = c_jump_;
  assign cif.flush_          = c_flush_;
  assign cif.commit_pc       = c_pc;
  assign cif.commit_rd       = c_rd;
  assign cif.commit_data     = c_data;
  assign cif.commit_exp_     = c_exp_;
  assign cif.commit_exp_code = c_code;
  assign cif.exp_handler_pc  = c_hpc;
  assign cif.commit_rob_id   = c_id;

  assign c8.commit_e_        = c_e_;
  assign c8.commit_jump_     = c_jump_;
  assign c8.flush_           = c_flush_;
  assign c8.commit_pc        = c_pc;
  assign c8.commit_rd        = c_rd;
  assign c8.commit_data      = c_data;
  assign c8.commit_exp_      = c_exp_;
  assign c8.commit_exp_code  = c_code;
  assign c8.exp_handler_pc   = c_hpc;
  assign c8.commit_rob_id    = c_id;

  commit_unit #(
    .DATA(32), .ADDR(32), .ROB_DEPTH(32),
    .FLUSH_CYCLES(2), .CNT(64)
  ) dut (
    .clk(clk), .reset(reset), .cif(cif)
  );

  commit_unit #(
    .DATA(32), .ADDR(32), .ROB_DEPTH(32),
    .FLUSH_CYCLES(2), .CNT(8)
  ) dut8 (
    .clk(clk), .reset(reset), .cif(c8)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic gpr(input logic [5:0] a, input logic [31:0] d,
                     input logic [4:0] id);
    c_e_ = 1'b0;
    c_rd = '{regtype: RF_GPR, addr: a};
    c_data = d;
    c_id = id;
  endtask

  task automatic idle();
    c_e_ = 1'b1;
    c_flush_ = 1'b1;
    c_exp_ = 1'b1;
    c_jump_ = 1'b1;
  endtask

  initial begin
    // reset values
    step();
    chk("rst_we", 64'(cif.arf_we_), 64'd1);
    chk("rst_waddr", 64'(cif.arf_waddr), 64'd0);
    chk("rst_wdata", 64'(cif.arf_wdata), 64'd0);
    chk("rst_redir", 64'(cif.redirect_e_), 64'd1);
    chk("rst_rpc", 64'(cif.redirect_pc), 64'd0);
    chk("rst_hold", 64'(cif.fe_hold), 64'd0);
    chk("rst_exp", 64'(cif.exp_e_), 64'd1);
    chk("rst_epc", 64'(cif.exp_epc), 64'd0);
    chk("rst_cause", 64'(cif.exp_cause), 64'd0);
    chk("rst_instret", cif.instret, 64'd0);
    chk("rst_rob", 64'(cif.last_rob_id), 64'd0);
    reset = 1'b0;

    // three back-to-back normal retires
    gpr(6'd5, 32'h11, 5'd3);
    step();
    chk("n1_we", 64'(cif.arf_we_), 64'd0);
    chk("n1_waddr", 64'(cif.arf_waddr), 64'd5);
    chk("n1_wdata", 64'(cif.arf_wdata), 64'h11);
    chk("n1_instret", cif.instret, 64'd1);
    gpr(6'd0, 32'h22, 5'd4);
    step();
    chk("n2_we", 64'(cif.arf_we_), 64'd1);
    chk("n2_instret", cif.instret, 64'd2);
    gpr(6'd7, 32'h33, 5'd5);
    step();
    chk("n3_we", 64'(cif.arf_we_), 64'd0);
    chk("n3_waddr", 64'(cif.arf_waddr), 64'd7);
    chk("n3_wdata", 64'(cif.arf_wdata), 64'h33);
    chk("n3_instret", cif.instret, 64'd3);
    chk("n3_rob", 64'(cif.last_rob_id), 64'd5);
    idle();
    step();
    chk("n4_we", 64'(cif.arf_we_), 64'd1);
    chk("n4_hold", 64'(cif.fe_hold), 64'd0);

    // mispredict flush, then a commit during the hold is dropped
    gpr(6'd1, 32'h0000_1040, 5'd6);
    c_flush_ = 1'b0;
    step();
    chk("f_we", 64'(cif.arf_we_), 64'd0);
    chk("f_waddr", 64'(cif.arf_waddr), 64'd1);
    chk("f_wdata", 64'(cif.arf_wdata), 64'h1040);
    chk("f_redir", 64'(cif.redirect_e_), 64'd0);
    chk("f_rpc", 64'(cif.redirect_pc), 64'h1040);
    chk("f_hold1", 64'(cif.fe_hold), 64'd1);
    chk("f_instret", cif.instret, 64'd4);
    c_flush_ = 1'b1;
    gpr(6'd9, 32'h99, 5'd7);
    step();
    chk("f_redir_off", 64'(cif.redirect_e_), 64'd1);
    chk("f_hold2", 64'(cif.fe_hold), 64'd1);
    chk("f_drop_we", 64'(cif.arf_we_), 64'd1);
    chk("f_drop_cnt", cif.instret, 64'd4);
    step();
    chk("f_hold3", 64'(cif.fe_hold), 64'd1);
    chk("f_drop_we2", 64'(cif.arf_we_), 64'd1);
    step();
    chk("f_hold_end", 64'(cif.fe_hold), 64'd0);
    chk("f_drop_cnt2", cif.instret, 64'd4);
    chk("f_rpc_hold", 64'(cif.redirect_pc), 64'h1040);
    idle();
    step();

    // exception beats flush; no write, no count
    gpr(6'd3, 32'h55, 5'd8);
    c_exp_ = 1'b0;
    c_flush_ = 1'b0;
    c_pc = 32'h200;
    c_code = EXP_ILLEGAL;
    c_hpc = 32'h8000_0000;
    step();
    chk("x_we", 64'(cif.arf_we_), 64'd1);
    chk("x_instret", cif.instret, 64'd4);
    chk("x_exp", 64'(cif.exp_e_), 64'd0);
    chk("x_epc", 64'(cif.exp_epc), 64'h200);
    chk("x_cause", 64'(cif.exp_cause), 64'd2);
    chk("x_redir", 64'(cif.redirect_e_), 64'd0);
    chk("x_rpc", 64'(cif.redirect_pc), 64'h8000_0000);
    chk("x_hold", 64'(cif.fe_hold), 64'd1);
    idle();
    step();
    chk("x_exp_off", 64'(cif.exp_e_), 64'd1);
    chk("x_cause_hold", 64'(cif.exp_cause), 64'd2);
    step();
    step();
    chk("x_hold_end", 64'(cif.fe_hold), 64'd0);

    // FPR destination: counted, not written
    c_e_ = 1'b0;
    c_rd = '{regtype: RF_FPR, addr: 6'd5};
    c_data = 32'h77;
    c_id = 5'd9;
    step();
    chk("fpr_we", 64'(cif.arf_we_), 64'd0 + 64'd1);
    chk("fpr_instret", cif.instret, 64'd5);

    // jump without flush retires with link write
    gpr(6'd1, 32'h44, 5'd10);
    c_jump_ = 1'b0;
    step();
    chk("j_we", 64'(cif.arf_we_), 64'd0);
    chk("j_wdata", 64'(cif.arf_wdata), 64'h44);
    chk("j_redir", 64'(cif.redirect_e_), 64'd1);
    chk("j_instret", cif.instret, 64'd6);
    chk("j_rob", 64'(cif.last_rob_id), 64'd10);
    idle();

    // reset in the middle of a drain
    gpr(6'd2, 32'h0000_2000, 5'd11);
    c_flush_ = 1'b0;
    step();
    chk("rd_hold1", 64'(cif.fe_hold), 64'd1);
    idle();
    step();
    chk("rd_hold2", 64'(cif.fe_hold), 64'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rd_hold", 64'(cif.fe_hold), 64'd0);
    chk("rd_instret", cif.instret, 64'd0);
    chk("rd_redir", 64'(cif.redirect_e_), 64'd1);
    chk("rd_exp", 64'(cif.exp_e_), 64'd1);
    chk("rd_we", 64'(cif.arf_we_), 64'd1);
    chk("rd_rpc", 64'(cif.redirect_pc), 64'd0);
    gpr(6'd2, 32'h5a, 5'd12);
    step();
    chk("rd_run_we", 64'(cif.arf_we_), 64'd0);
    chk("rd_run_cnt", cif.instret, 64'd1);
    idle();

    // 256 retires: 8-bit counter wraps, 64-bit does not
    reset = 1'b1;
    step();
    reset = 1'b0;
    gpr(6'd0, 32'h0, 5'd0);
    for (int i = 0; i < 255; i++) step();
    chk("w8_255", 64'(c8.instret), 64'd255);
    step();
    chk("w8_wrap", 64'(c8.instret), 64'd0);
    chk("w64_256", cif.instret, 64'd256);
    idle();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
